// File: rtl/grant_decoder_3to8.sv
// Sequential one-hot grant dispatcher: accepts an encoded channel index over valid/ready
// and holds the matching grant line until that agent signals done or the timeout expires.
module grant_decoder_3to8 #(
    parameter int  N_CH    = 8,
    parameter int  TIMEOUT = 16,
    parameter int  CNT_W   = 8,
    localparam int IDX_W   = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idx_valid,
    output logic             idx_ready,
    input  logic [IDX_W-1:0] idx,
    output logic [N_CH-1:0]  gnt,
    input  logic [N_CH-1:0]  done,
    output logic             busy,
    output logic             bad_idx,
    output logic             timeout_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    gnt_q, gnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               bad_idx_q, bad_idx_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               accept;
    logic               idx_in_range;
    logic               done_cur;
    logic               timer_expired;

    assign idx_ready     = (state_q == IDLE) && !rst;
    assign accept        = idx_valid && idx_ready;
    assign idx_in_range  = {1'b0, idx} < (IDX_W + 1)'(N_CH);
    // gnt_q is one-hot on the granted channel, so masking done with it observes only done[cur].
    assign done_cur      = |(done & gnt_q);
    assign timer_expired = (TIMEOUT > 0) && (timer_q == TMR_LAST);

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        timer_d       = timer_q;
        bad_idx_d     = 1'b0;
        timeout_err_d = 1'b0;
        err_cnt_d     = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (idx_in_range) begin
                        state_d = GRANT;
                        gnt_d   = N_CH'(1) << idx;
                        timer_d = '0;
                    end else begin
                        bad_idx_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                timer_d = timer_q + 1'b1;
                // done takes priority over a timeout landing in the same cycle.
                if (done_cur) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (timer_expired) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    timeout_err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            timer_q       <= '0;
            bad_idx_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            timer_q       <= timer_d;
            bad_idx_q     <= bad_idx_d;
            timeout_err_q <= timeout_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q == GRANT);
    assign bad_idx     = bad_idx_q;
    assign timeout_err = timeout_err_q;
    assign err_cnt     = err_cnt_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_iff_busy: assert property (@(posedge clk) disable iff (rst)
        ((gnt_q != '0) == (state_q == GRANT)));

endmodule
